// File: rtl/pkt_meta_pkg.sv
// Shared definitions for the packet metadata tagger: defaults, header layout, FSM states.
package pkt_meta_pkg;
  localparam int FLOW_W_DEF  = 8;
  localparam int NUM_MAX_DEF = 7;
  localparam int CNT_MAX_DEF = 63;

  localparam int HDR_PROTO_LSB = 56;
  localparam int HDR_FLOW_LSB  = 48;
  localparam int HDR_LEN_LSB   = 40;
  localparam int HDR_FIELD_W   = 8;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_PAYLOAD
  } state_t;
endpackage

// File: rtl/flow_pkt_cnt_tbl.sv
// Per-flow saturating packet counter table: clear-sweep write port plus one
// read-modify-write port (combinational read, registered write-back).
module flow_pkt_cnt_tbl #(
  parameter int FLOW_W  = 8,
  parameter int NUM_MAX = 7,
  localparam int NUM_W  = $clog2(NUM_MAX + 1)
) (
  input  logic              i_clk,
  input  logic              clr_en,
  input  logic [FLOW_W-1:0] clr_addr,
  input  logic              rmw_en,
  input  logic [FLOW_W-1:0] rmw_addr,
  output logic [NUM_W-1:0]  rmw_next
);
  logic [NUM_W-1:0] mem [2**FLOW_W];
  logic [NUM_W-1:0] cur;

  always_comb begin
    cur      = mem[rmw_addr];
    rmw_next = (cur >= NUM_W'(NUM_MAX)) ? cur : cur + 1'b1;
  end

  // Sweep has priority; both ports are never active in the same FSM state.
  always_ff @(posedge i_clk) begin
    if (clr_en)
      mem[clr_addr] <= '0;
    else if (rmw_en)
      mem[rmw_addr] <= rmw_next;
  end
endmodule

// File: rtl/pkt_meta_tagger.sv
// Strips the metadata header from a framed beat stream and tags each payload
// beat with protocol, flow id, length, beat index and per-flow packet ordinal.
module pkt_meta_tagger
  import pkt_meta_pkg::*;
#(
  parameter int FLOW_W  = FLOW_W_DEF,
  parameter int NUM_MAX = NUM_MAX_DEF,
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  input  logic                           i_sop,
  input  logic                           i_eop,
  input  logic [63:0]                    i_data,
  output logic                           o_ready,
  output logic                           o_pkt_data_valid,
  output logic [63:0]                    o_pkt_data,
  output logic [7:0]                     o_pkt_len,
  output logic [$clog2(NUM_MAX+1)-1:0]   o_pkt_num,
  output logic [7:0]                     o_pkt_protocol,
  output logic [$clog2(CNT_MAX+1)-1:0]   o_pkt_cycle_cnt,
  output logic [FLOW_W-1:0]              o_flow_id,
  output logic                           o_err
);
  localparam int NUM_W = $clog2(NUM_MAX + 1);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  state_t            state, state_d;
  logic [FLOW_W-1:0] clr_addr;
  logic              tbl_clr, hdr_take, emit, err_d;
  logic [NUM_W-1:0]  rmw_next;
  logic [7:0]        hdr_proto, hdr_len;
  logic [FLOW_W-1:0] hdr_flow;
  logic [NUM_W-1:0]  hdr_num;
  logic [CNT_W-1:0]  beat_cnt, beat_inc;

  flow_pkt_cnt_tbl #(
    .FLOW_W (FLOW_W),
    .NUM_MAX(NUM_MAX)
  ) u_tbl (
    .i_clk   (i_clk),
    .clr_en  (tbl_clr),
    .clr_addr(clr_addr),
    .rmw_en  (hdr_take),
    .rmw_addr(i_data[HDR_FLOW_LSB +: FLOW_W]),
    .rmw_next(rmw_next)
  );

  assign beat_inc = (beat_cnt == CNT_W'(CNT_MAX)) ? beat_cnt : beat_cnt + 1'b1;

  always_comb begin
    state_d  = state;
    tbl_clr  = 1'b0;
    hdr_take = 1'b0;
    emit     = 1'b0;
    err_d    = 1'b0;
    case (state)
      ST_CLEAR: begin
        tbl_clr = 1'b1;
        if (clr_addr == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (i_valid) begin
          if (i_sop) begin
            hdr_take = 1'b1;
            state_d  = i_eop ? ST_IDLE : ST_PAYLOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (i_valid) begin
          // A sop here truncates the open packet and starts a new one.
          if (i_sop) begin
            hdr_take = 1'b1;
            err_d    = 1'b1;
            state_d  = i_eop ? ST_IDLE : ST_PAYLOAD;
          end else begin
            emit = 1'b1;
            if (i_eop) state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= ST_CLEAR;
      clr_addr         <= '0;
      hdr_proto        <= '0;
      hdr_flow         <= '0;
      hdr_len          <= '0;
      hdr_num          <= '0;
      beat_cnt         <= '0;
      o_ready          <= 1'b0;
      o_err            <= 1'b0;
      o_pkt_data_valid <= 1'b0;
      o_pkt_data       <= '0;
      o_pkt_len        <= '0;
      o_pkt_num        <= '0;
      o_pkt_protocol   <= '0;
      o_pkt_cycle_cnt  <= '0;
      o_flow_id        <= '0;
    end else begin
      state            <= state_d;
      o_ready          <= (state_d != ST_CLEAR);
      o_err            <= err_d;
      o_pkt_data_valid <= emit;
      if (tbl_clr) clr_addr <= clr_addr + 1'b1;
      if (hdr_take) begin
        hdr_proto <= i_data[HDR_PROTO_LSB +: HDR_FIELD_W];
        hdr_flow  <= i_data[HDR_FLOW_LSB +: FLOW_W];
        hdr_len   <= i_data[HDR_LEN_LSB +: HDR_FIELD_W];
        hdr_num   <= rmw_next;
        beat_cnt  <= '0;
      end else if (emit) begin
        beat_cnt <= beat_inc;
      end
      // Tags are copied from the latched header only with a payload beat so
      // they hold steady while valid is low.
      if (emit) begin
        o_pkt_data      <= i_data;
        o_pkt_len       <= hdr_len;
        o_pkt_num       <= hdr_num;
        o_pkt_protocol  <= hdr_proto;
        o_pkt_cycle_cnt <= beat_inc;
        o_flow_id       <= hdr_flow;
      end
    end
  end
endmodule

// File: doc/pkt_meta_tagger.md
# pkt_meta_tagger

Upstream stage feeding the protocol parsers (SSH banner match, SNI match). Consumes a framed 64-bit beat stream whose first beat is a metadata header. Strips the header and emits payload beats tagged with protocol, flow id, length, per-packet beat index (cycle_cnt) and per-flow packet ordinal (pkt_num). Keeps a 256-entry per-flow packet counter table.

## Interface
Parameters:
- FLOW_W, 8, flow id width; table depth 2^FLOW_W
- NUM_MAX, 7, saturation value of pkt_num (3-bit)
- CNT_MAX, 63, saturation value of cycle_cnt (6-bit)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  input beat valid
- i_sop  in  1  beat is the header beat
- i_eop  in  1  beat is the last payload beat
- i_data  in  64  header or payload word
- o_ready  out  1  high when beats are accepted; low during table clear
- o_pkt_data_valid  out  1  payload beat valid
- o_pkt_data  out  64  payload word
- o_pkt_len  out  8  payload length from header
- o_pkt_num  out  3  per-flow packet ordinal, 1-based
- o_pkt_protocol  out  8  IP protocol from header
- o_pkt_cycle_cnt  out  6  payload beat index, 1-based
- o_flow_id  out  8  flow id from header
- o_err  out  1  one-cycle pulse on framing error

## Operation
- Header beat layout: [63:56] protocol, [55:48] flow_id, [47:40] len; [39:0] ignored.
- FSM states: CLEAR, IDLE, PAYLOAD.
- CLEAR: entered on reset. Sweeps the table, writing 0 to one entry per cycle, addresses 0..255. o_ready=0. Moves to IDLE after entry 255 is written.
- IDLE:
  - Accepts a beat with i_valid&i_sop.
  - Latches protocol, flow_id and len.
  - Reads table[flow_id] = n and writes back min(n+1, NUM_MAX).
  - Latches pkt_num = min(n+1, NUM_MAX).
  - Clears the beat counter and moves to PAYLOAD.
  - A valid beat without sop is dropped and pulses o_err.
- PAYLOAD: each valid beat increments the beat counter (saturating at CNT_MAX). The beat is emitted with the latched tags and cycle_cnt = counter value (first payload beat = 1).
  - i_eop: emit the beat, then go to IDLE.
  - i_sop in PAYLOAD (missing eop): the current packet is truncated, o_err pulses, and the beat is processed as a new header exactly as in IDLE.
  - A beat carrying both sop and eop is a header-only packet: table updated, no output, stay in IDLE.
- The table read-modify-write completes within the header cycle (combinational read, registered write). Consecutive same-flow packets therefore see the updated value; the minimum spacing is header + 1 payload beat.
- Header beats never produce output. The header beat does not advance cycle_cnt.
- o_pkt_len is passed through as-is; it is not checked against the actual beat count.

## Timing
- Payload beat accepted at cycle t → outputs valid at t+1. All outputs are registered.
- o_pkt_data_valid is low in every cycle with no accepted payload beat. Tag outputs hold their last values while valid is low.
- Reset values: o_pkt_data_valid=0, o_err=0, o_ready=0, all data/tag outputs 0.
- o_ready rises exactly 256 cycles after i_rst deasserts.
- Beats offered while o_ready=0 are dropped silently, with no o_err.
- i_rst asserted mid-packet: FSM returns to CLEAR and the table is re-cleared. The next cycle has o_pkt_data_valid=0. There is no partial output after reset.
- No backpressure from downstream; o_ready depends only on the FSM state.

## Structure
- Shared package pkt_meta_pkg:
  - header field bit positions;
  - FSM state enum;
  - FLOW_W, NUM_MAX, CNT_MAX defaults.
- Sub-module flow_pkt_cnt_tbl: 2^FLOW_W x 3 register array with the clear-sweep port and a single read-modify-write port.

## Test plan
- Reset release → o_ready=0 for 256 cycles, then 1; sample entries 0, 128, 255 read 0 via first-packet pkt_num=1.
- Header {06, 2A, 03} + 3 payload beats (last eop) → 3 output beats with protocol 0x06, flow 0x2A, len 3, cycle_cnt 1,2,3, pkt_num 1, one cycle later.
- Nine back-to-back packets on flow 0x05 (header + 1 beat each) → pkt_num 1..7, then 7,7; flow 0x06 interleaved stays independent at 1.
- 70-beat payload → cycle_cnt 1..63, then 63 for beats 64..70.
- Header for flow 0x10, 2 beats, then sop without eop → o_err pulse, second packet tagged pkt_num 1 for its own flow; a stray non-sop beat in IDLE → dropped, o_err.
- i_rst mid-payload → outputs invalid next cycle, o_ready low 256 cycles, flow 0x2A restarts at pkt_num 1.
